// File: rtl/data_memory_ls_if.sv
// Request/response bus of the MEM-stage data memory: one request in flight,
// one response pulse per accepted request.
interface data_memory_ls_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  reqValid;
   logic                  reqReady;
   logic                  reqWrite;
   logic [1:0]            reqSize;
   logic                  reqUnsigned;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] dataWrite;
   logic                  respValid;
   logic [DATA_WIDTH-1:0] dataOutput;
   logic                  misaligned;

   modport master (
      output reqValid, reqWrite, reqSize, reqUnsigned, address, dataWrite,
      input  reqReady, respValid, dataOutput, misaligned
   );

   modport slave (
      input  reqValid, reqWrite, reqSize, reqUnsigned, address, dataWrite,
      output reqReady, respValid, dataOutput, misaligned
   );
endinterface

// File: rtl/data_memory_ls.sv
// Byte-addressed little-endian data memory with byte/half/word access and configurable read latency.
// Optional feature macro DMEM_MISALIGN_CHECK_EN: flag misaligned accesses instead of forcing alignment.
module data_memory_ls #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 256,
   parameter int READ_LATENCY = 1
) (
   input logic             clk,
   input logic             rst,
   data_memory_ls_if.slave bus
);
   localparam int         IDX_W       = $clog2(DEPTH_WORDS);
   localparam logic [1:0] WAIT_INIT_C = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

   state_e                state_q;
   logic                  ready_q;
   logic                  resp_valid_q;
   logic                  mis_q;
   logic                  pend_mis_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] pend_data_q;
   logic [1:0]            cnt_q;

   logic                  is_word_s;
   logic                  is_half_s;
   logic [IDX_W-1:0]      idx_s;
   logic [1:0]            lane_s;
   logic                  mis_s;
   logic                  accept_s;
   logic                  we_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [7:0]            ld_byte_s;
   logic [15:0]           ld_half_s;
   logic [DATA_WIDTH-1:0] ld_data_s;
   logic [3:0]            be_s;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic                  unused_addr_s;

   assign is_word_s     = bus.reqSize[1];
   assign is_half_s     = (bus.reqSize == 2'd1);
   assign idx_s         = bus.address[IDX_W+1:2];
   assign unused_addr_s = ^bus.address[ADDR_WIDTH-1:IDX_W+2];
   assign accept_s      = bus.reqValid && ready_q;
   assign we_s          = accept_s && bus.reqWrite && !mis_s;
   assign rd_word_s     = mem_q[idx_s];

   // Lane selection and misalignment decision for the presented request
   always_comb begin
      lane_s = bus.address[1:0];
`ifdef DMEM_MISALIGN_CHECK_EN
      mis_s = (is_half_s && bus.address[0]) || (is_word_s && (bus.address[1:0] != 2'b00));
`else
      mis_s = 1'b0;
      if (is_word_s) begin
         lane_s = 2'b00;
      end else if (is_half_s) begin
         lane_s = {bus.address[1], 1'b0};
      end else begin
         lane_s = bus.address[1:0];
      end
`endif
   end

   // Load extraction and sign/zero extension from the word as it is before this edge
   always_comb begin
      case (lane_s)
         2'd0:    ld_byte_s = rd_word_s[7:0];
         2'd1:    ld_byte_s = rd_word_s[15:8];
         2'd2:    ld_byte_s = rd_word_s[23:16];
         default: ld_byte_s = rd_word_s[31:24];
      endcase
      ld_half_s = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      if (mis_s) begin
         ld_data_s = {DATA_WIDTH{1'b0}};
      end else if (is_word_s) begin
         ld_data_s = rd_word_s;
      end else if (is_half_s) begin
         ld_data_s = bus.reqUnsigned ? {16'h0000, ld_half_s} : {{16{ld_half_s[15]}}, ld_half_s};
      end else begin
         ld_data_s = bus.reqUnsigned ? {24'h000000, ld_byte_s} : {{24{ld_byte_s[7]}}, ld_byte_s};
      end
   end

   // Store byte enables and lane-replicated write data
   always_comb begin
      if (is_word_s) begin
         be_s    = 4'b1111;
         wdata_s = bus.dataWrite;
      end else if (is_half_s) begin
         be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
         wdata_s = {2{bus.dataWrite[15:0]}};
      end else begin
         be_s    = 4'b0001 << lane_s;
         wdata_s = {4{bus.dataWrite[7:0]}};
      end
   end

   // Storage array: cleared on reset, byte-lane writes at store acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (we_s) begin
         for (int l = 0; l < 4; l++) begin
            if (be_s[l]) begin
               mem_q[idx_s][8*l +: 8] <= wdata_s[8*l +: 8];
            end
         end
      end
   end

   // Request FSM with registered response outputs; load data is snapshotted at acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         mis_q        <= 1'b0;
         data_q       <= {DATA_WIDTH{1'b0}};
         pend_mis_q   <= 1'b0;
         pend_data_q  <= {DATA_WIDTH{1'b0}};
         cnt_q        <= 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               resp_valid_q <= 1'b0;
               mis_q        <= 1'b0;
               data_q       <= {DATA_WIDTH{1'b0}};
               if (accept_s) begin
                  ready_q <= 1'b0;
                  if (bus.reqWrite) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     mis_q        <= mis_s;
                  end else if (READ_LATENCY > 1) begin
                     state_q     <= ST_WAIT;
                     cnt_q       <= WAIT_INIT_C;
                     pend_data_q <= ld_data_s;
                     pend_mis_q  <= mis_s;
                  end else begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     mis_q        <= mis_s;
                     data_q       <= ld_data_s;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 2'd0) begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  mis_q        <= pend_mis_q;
                  data_q       <= pend_data_q;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            ST_RESP: begin
               state_q      <= ST_IDLE;
               ready_q      <= 1'b1;
               resp_valid_q <= 1'b0;
               mis_q        <= 1'b0;
               data_q       <= {DATA_WIDTH{1'b0}};
            end
            default: begin
               state_q      <= ST_IDLE;
               ready_q      <= 1'b1;
               resp_valid_q <= 1'b0;
               mis_q        <= 1'b0;
               data_q       <= {DATA_WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign bus.reqReady   = ready_q;
   assign bus.respValid  = resp_valid_q;
   assign bus.dataOutput = data_q;
   assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls: one instance with READ_LATENCY=1, one with READ_LATENCY=3.
module tb_data_memory_ls;
   logic        clk;
   logic        rst;
   logic [1:0]  rv;
   logic        wr;
   logic [1:0]  sz;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wd;
   int          n_checks;
   int          n_err;

   data_memory_ls_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();
   data_memory_ls_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();

   assign if1.reqValid    = rv[0];
   assign if1.reqWrite    = wr;
   assign if1.reqSize     = sz;
   assign if1.reqUnsigned = uns;
   assign if1.address     = addr;
   assign if1.dataWrite   = wd;
   assign if3.reqValid    = rv[1];
   assign if3.reqWrite    = wr;
   assign if3.reqSize     = sz;
   assign if3.reqUnsigned = uns;
   assign if3.address     = addr;
   assign if3.dataWrite   = wd;

   data_memory_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1)
   );
   data_memory_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .bus(if3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One request on instance sel (0: latency 1, 1: latency 3); returns response data, flag and latency
   task automatic req(input int sel, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] dout, output logic mis, output int lat);
      int n;
      wr = w; sz = s; uns = u; addr = a; wd = d;
      rv[sel] = 1'b1;
      n = 0;
      while (((sel == 0) ? if1.reqReady : if3.reqReady) !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      rv[sel] = 1'b0;
      lat = 0; dout = 32'hDEADBEEF; mis = 1'bx;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (((sel == 0) ? if1.respValid : if3.respValid) === 1'b1) begin
            dout = (sel == 0) ? if1.dataOutput : if3.dataOutput;
            mis  = (sel == 0) ? if1.misaligned : if3.misaligned;
            break;
         end
      end
      if (lat >= 10) lat = 99;
      @(posedge clk); #1;
   endtask

   logic [31:0] d;
   logic        m;
   int          l;
   logic [7:0]  rdy_vec;
   logic [7:0]  val_vec;
   logic [31:0] d_first;
   logic [31:0] d_second;
   logic        seen;
   logic [31:0] exp_m;
   logic [31:0] exp_w44;
   logic [31:0] exp_h43;

   initial begin
      n_checks = 0; n_err = 0;
      rst = 1'b1; rv = 2'b00; wr = 1'b0; sz = 2'd0; uns = 1'b0; addr = 32'd0; wd = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready1", {31'd0, if1.reqReady}, 32'd1);
      chk("rst_ready3", {31'd0, if3.reqReady}, 32'd1);
      chk("rst_resp",   {31'd0, if1.respValid}, 32'd0);
      chk("rst_dout",   if1.dataOutput, 32'd0);
      chk("rst_mis",    {31'd0, if1.misaligned}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", {31'd0, if1.reqReady}, 32'd1);

      req(0, 1'b0, 2'd2, 1'b0, 32'd36, 32'd0, d, m, l);
      chk("ld36_rst", d, 32'h00000000);
      chk("ld36_lat", l, 32'd1);

      req(0, 1'b1, 2'd2, 1'b0, 32'd36, 32'h00000055, d, m, l);
      chk("st36_lat", l, 32'd1);
      chk("st36_dout", d, 32'd0);
      req(0, 1'b0, 2'd2, 1'b0, 32'd36, 32'd0, d, m, l);
      chk("ld36", d, 32'h00000055);
      chk("ld36_lat2", l, 32'd1);
      req(0, 1'b0, 2'd2, 1'b0, 32'd36 + 32'd1024, 32'd0, d, m, l);
      chk("ld36_wrap", d, 32'h00000055);

      req(0, 1'b1, 2'd2, 1'b0, 32'd40, 32'hFFFFFFFF, d, m, l);
      req(0, 1'b1, 2'd0, 1'b0, 32'd41, 32'hABCDEF0C, d, m, l);
      req(0, 1'b1, 2'd1, 1'b0, 32'd42, 32'h12348001, d, m, l);
      req(0, 1'b0, 2'd2, 1'b0, 32'd40, 32'd0, d, m, l);
      chk("ld40_lanes", d, 32'h80010CFF);
      req(0, 1'b0, 2'd2, 1'b1, 32'd40, 32'd0, d, m, l);
      chk("ld40_uns", d, 32'h80010CFF);
      req(0, 1'b0, 2'd0, 1'b0, 32'd43, 32'd0, d, m, l);
      chk("lb43_s", d, 32'hFFFFFF80);
      req(0, 1'b0, 2'd0, 1'b1, 32'd43, 32'd0, d, m, l);
      chk("lb43_u", d, 32'h00000080);
      req(0, 1'b0, 2'd0, 1'b0, 32'd41, 32'd0, d, m, l);
      chk("lb41_s", d, 32'h0000000C);
      req(0, 1'b0, 2'd1, 1'b0, 32'd42, 32'd0, d, m, l);
      chk("lh42_s", d, 32'hFFFF8001);
      req(0, 1'b0, 2'd1, 1'b1, 32'd42, 32'd0, d, m, l);
      chk("lh42_u", d, 32'h00008001);

`ifdef DMEM_MISALIGN_CHECK_EN
      exp_m = 32'd1; exp_w44 = 32'h00000000; exp_h43 = 32'h00000000;
`else
      exp_m = 32'd0; exp_w44 = 32'h12345678; exp_h43 = 32'hFFFF8001;
`endif
      req(0, 1'b1, 2'd2, 1'b0, 32'd45, 32'h12345678, d, m, l);
      chk("st45_mis", {31'd0, m}, exp_m);
      chk("st45_lat", l, 32'd1);
      req(0, 1'b0, 2'd2, 1'b0, 32'd44, 32'd0, d, m, l);
      chk("ld44", d, exp_w44);
      chk("ld44_mis", {31'd0, m}, 32'd0);
      req(0, 1'b0, 2'd1, 1'b0, 32'd43, 32'd0, d, m, l);
      chk("lh43", d, exp_h43);
      chk("lh43_mis", {31'd0, m}, exp_m);

      req(1, 1'b1, 2'd2, 1'b0, 32'd8, 32'hA5A51234, d, m, l);
      chk("l3_st_lat", l, 32'd1);

      // Two back-to-back loads with reqValid held high on the latency-3 instance
      wr = 1'b0; sz = 2'd2; uns = 1'b0; addr = 32'd8;
      rv[1] = 1'b1;
      rdy_vec = 8'd0; val_vec = 8'd0; d_first = 32'd0; d_second = 32'd0;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         rdy_vec[c-1] = if3.reqReady;
         val_vec[c-1] = if3.respValid;
         if (c == 3) d_first = if3.dataOutput;
         if (c == 7) d_second = if3.dataOutput;
         if (c == 4) begin
            @(posedge clk); #1;
            rv[1] = 1'b0;
         end
      end
      chk("l3_ready_pat", {24'd0, rdy_vec}, 32'h00000088);
      chk("l3_valid_pat", {24'd0, val_vec}, 32'h00000044);
      chk("l3_data1", d_first, 32'hA5A51234);
      chk("l3_data2", d_second, 32'hA5A51234);
      @(posedge clk); #1;

      // Reset while the latency-3 load is waiting
      addr = 32'd8; rv[1] = 1'b1;
      @(posedge clk); #1;
      rv[1] = 1'b0;
      @(negedge clk);
      chk("mid_wait_ready", {31'd0, if3.reqReady}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, if3.reqReady}, 32'd1);
      seen = if3.respValid;
      repeat (5) begin
         @(negedge clk);
         if (if3.respValid === 1'b1) seen = 1'b1;
      end
      chk("mid_rst_noresp", {31'd0, seen}, 32'd0);
      @(posedge clk); #1;

      req(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'd0, d, m, l);
      chk("l3_ld_cleared", d, 32'h00000000);
      chk("l3_ld_lat", l, 32'd3);
      req(0, 1'b0, 2'd2, 1'b0, 32'd36, 32'd0, d, m, l);
      chk("ld36_cleared", d, 32'h00000000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
